// File: rtl/vga_timing_if.sv
// vga_timing_if: pixel-timing bundle from the timing source to every pixel consumer.
//   hCount/vCount  current pixel / line position
//   hSync/vSync    sync pulses (polarity chosen at build time by the source)
//   bright         1 inside the visible window
//   pix_tick       1-clk pulse per pixel period
//   frame_tick     1-clk pulse when the position wraps to (0,0)
// Modports: master = timing source (drives everything), slave = consumer.
interface vga_timing_if;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       pix_tick;
    logic       frame_tick;

    modport master (
        output hCount, vCount, hSync, vSync, bright, pix_tick, frame_tick
    );
    modport slave (
        input  hCount, vCount, hSync, vSync, bright, pix_tick, frame_tick
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing source.
//   Divides clk by CLK_DIV to a pixel rate, walks (hCount,vCount) over the full
//   H_TOT x V_TOT raster and decodes sync/bright from the same registered position
//   so consumers see them with zero skew against the counters.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous, active-high reset
//   vga   vga_timing_if.master  counters, syncs, bright, pix_tick, frame_tick
// Build option:
//   SYNC_POS_POLARITY_EN  when defined, hSync/vSync are active-high (and reset to 1);
//                         otherwise active-low (standard 640x480@60).
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FP    = 10
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_if.master vga
);
    localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned CNT_W = 10;
    // One extra bit so window bounds equal to 1024 still compare correctly.
    localparam int unsigned CMP_W = CNT_W + 1;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

`ifdef SYNC_POS_POLARITY_EN
    localparam logic SYNC_ON = 1'b1;
`else
    localparam logic SYNC_ON = 1'b0;
`endif

    // Reject geometries the 10-bit counters cannot represent.
    if (H_TOT > 1024 || V_TOT > 1024 || CLK_DIV < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_cfg_check
        $error("vga_timing_gen: unsupported timing configuration");
    end

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             hs_q;
    logic             vs_q;
    logic             br_q;
    logic             pt_q;
    logic             ft_q;
    logic             advance_c;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             br_nxt;
    logic             ft_nxt;
    logic             h_vis_c;
    logic             v_vis_c;

    // Next position and its decode; sync/bright come from the NEW position.
    always_comb begin
        advance_c = (div_cnt == DIV_W'(CLK_DIV - 1));
        div_nxt   = advance_c ? '0 : div_cnt + DIV_W'(1);
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        if (advance_c) begin
            if (h_cnt == CNT_W'(H_TOT - 1)) begin
                h_nxt = '0;
                v_nxt = (v_cnt == CNT_W'(V_TOT - 1)) ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_nxt = h_cnt + CNT_W'(1);
            end
        end
        hs_nxt  = ({1'b0, h_nxt} < CMP_W'(H_SYNC)) ? SYNC_ON : ~SYNC_ON;
        vs_nxt  = ({1'b0, v_nxt} < CMP_W'(V_SYNC)) ? SYNC_ON : ~SYNC_ON;
        h_vis_c = ({1'b0, h_nxt} >= CMP_W'(H_SYNC + H_BP)) &&
                  ({1'b0, h_nxt} <  CMP_W'(H_SYNC + H_BP + H_ACT));
        v_vis_c = ({1'b0, v_nxt} >= CMP_W'(V_SYNC + V_BP)) &&
                  ({1'b0, v_nxt} <  CMP_W'(V_SYNC + V_BP + V_ACT));
        br_nxt  = h_vis_c && v_vis_c;
        ft_nxt  = advance_c && (h_nxt == '0) && (v_nxt == '0);
    end

    // Between advance edges the next position equals the current one, so the
    // decoded outputs simply hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hs_q    <= SYNC_ON;
            vs_q    <= SYNC_ON;
            br_q    <= 1'b0;
            pt_q    <= 1'b0;
            ft_q    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            hs_q    <= hs_nxt;
            vs_q    <= vs_nxt;
            br_q    <= br_nxt;
            pt_q    <= advance_c;
            ft_q    <= ft_nxt;
        end
    end

    assign vga.hCount     = h_cnt;
    assign vga.vCount     = v_cnt;
    assign vga.hSync      = hs_q;
    assign vga.vSync      = vs_q;
    assign vga.bright     = br_q;
    assign vga.pix_tick   = pt_q;
    assign vga.frame_tick = ft_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three timing generators (two small rasters, one 640x480@60)
// share clk/rst; random mid-frame resets. A reference model derives every output
// from the number of un-reset clk edges, a scoreboard queue per DUT carries the
// expectation to a monitor that compares on the falling edge.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       pt;
        logic       ft;
    } exp_t;

    localparam int NDUT = 3;
    localparam int DIV [NDUT] = '{3, 1, 4};
    localparam int HS  [NDUT] = '{3, 2, 96};
    localparam int HB  [NDUT] = '{2, 1, 48};
    localparam int HA  [NDUT] = '{6, 5, 640};
    localparam int HF  [NDUT] = '{2, 1, 16};
    localparam int VS  [NDUT] = '{2, 1, 2};
    localparam int VB  [NDUT] = '{2, 1, 33};
    localparam int VA  [NDUT] = '{4, 3, 480};
    localparam int VF  [NDUT] = '{1, 2, 10};

`ifdef SYNC_POS_POLARITY_EN
    localparam bit SYNC_ON = 1'b1;
`else
    localparam bit SYNC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_timing_if vif0 ();
    vga_timing_if vif1 ();
    vga_timing_if vif2 ();

    vga_timing_gen #(
        .CLK_DIV(3), .H_SYNC(3), .H_BP(2), .H_ACT(6), .H_FP(2),
        .V_SYNC(2), .V_BP(2), .V_ACT(4), .V_FP(1)
    ) dut0 (.clk(clk), .rst(rst), .vga(vif0));

    vga_timing_gen #(
        .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_ACT(5), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(2)
    ) dut1 (.clk(clk), .rst(rst), .vga(vif1));

    vga_timing_gen dut2 (.clk(clk), .rst(rst), .vga(vif2));

    exp_t obs [NDUT];
    assign obs[0] = {vif0.hCount, vif0.vCount, vif0.hSync, vif0.vSync, vif0.bright, vif0.pix_tick, vif0.frame_tick};
    assign obs[1] = {vif1.hCount, vif1.vCount, vif1.hSync, vif1.vSync, vif1.bright, vif1.pix_tick, vif1.frame_tick};
    assign obs[2] = {vif2.hCount, vif2.vCount, vif2.hSync, vif2.vSync, vif2.bright, vif2.pix_tick, vif2.frame_tick};

    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];
    int   k [NDUT] = '{0, 0, 0};
    int   n_checks = 0;
    int   n_fail   = 0;

    // Expected outputs after k un-reset clk edges: k/DIV pixels have elapsed,
    // position is that pixel index folded onto the raster.
    function automatic exp_t model(int d, int kk);
        exp_t e;
        int   ht;
        int   vt;
        int   n;
        int   h;
        int   v;
        bit   tick;
        ht   = HS[d] + HB[d] + HA[d] + HF[d];
        vt   = VS[d] + VB[d] + VA[d] + VF[d];
        n    = (kk / DIV[d]) % (ht * vt);
        h    = n % ht;
        v    = n / ht;
        tick = (kk > 0) && (kk % DIV[d] == 0);
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h < HS[d]) ? SYNC_ON : ~SYNC_ON;
        e.vs = (v < VS[d]) ? SYNC_ON : ~SYNC_ON;
        e.br = (h >= HS[d] + HB[d]) && (h < HS[d] + HB[d] + HA[d]) &&
               (v >= VS[d] + VB[d]) && (v < VS[d] + VB[d] + VA[d]);
        e.pt = tick;
        e.ft = tick && (n == 0);
        return e;
    endfunction

    task automatic push_exp(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int d, output bit ok, output exp_t e);
        ok = 1'b0;
        e  = '0;
        case (d)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    // Model: count edges taken out of reset; an async reset after the edge also clears.
    initial begin
        bit rst_edge;
        forever begin
            @(posedge clk);
            rst_edge = rst;
            #2;
            for (int d = 0; d < NDUT; d++) begin
                if (rst || rst_edge) k[d] = 0;
                else                 k[d] = k[d] + 1;
                push_exp(d, model(d, k[d]));
            end
        end
    end

    // Monitor: one comparison per DUT per falling edge.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            for (int d = 0; d < NDUT; d++) begin
                pop_exp(d, ok, e);
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL sb_empty dut%0d t=%0t: no expectation queued", d, $time);
                end else if (obs[d] !== e) begin
                    n_fail++;
                    if (n_fail <= 20)
                        $display("FAIL dut%0d k=%0d t=%0t got h=%0d v=%0d hs=%b vs=%b br=%b pt=%b ft=%b exp h=%0d v=%0d hs=%b vs=%b br=%b pt=%b ft=%b",
                                 d, k[d], $time, obs[d].h, obs[d].v, obs[d].hs, obs[d].vs, obs[d].br,
                                 obs[d].pt, obs[d].ft, e.h, e.v, e.hs, e.vs, e.br, e.pt, e.ft);
                end
            end
        end
    end

    // Stimulus: initial reset, a long run (several lines of the 640x480 raster),
    // then random mid-frame resets of random length.
    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (7000) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1 rst = 1'b1;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 rst = 1'b0;
            repeat ($urandom_range(300, 2000)) @(posedge clk);
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
